// File: rtl/mcf_source_multich_if.sv
// Sample stream toward axi_wrapper: data, last, valid/ready and the 128-bit packet header.
// The master drives everything except tready.
interface mcf_source_multich_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;
    logic [127:0]      tuser;

    modport master (output tdata, tlast, tvalid, tuser, input tready);
    modport slave  (input tdata, tlast, tvalid, tuser, output tready);
endinterface

// File: rtl/mcf_source_multich.sv
// Paced, counter-patterned burst source serving NUM_CH channels round-robin; MCF_SRC_TIMESTAMP_EN adds header timestamps.
// Latency: one SELECT cycle per burst, then one sample per divider tick (tick -> tvalid next cycle).
// Backpressure: tvalid holds until tready; ticks lost while stalled set the sticky overrun flag.
module mcf_source_multich #(
    parameter int NUM_CH            = 4,
    parameter int DATA_W            = 32,
    parameter int SR_ENABLE         = 129,
    parameter int SR_SAMPLE_LEN_1MS = 130,
    parameter int SR_SPP            = 131,
    parameter int SR_CLK_DIV        = 132,
    parameter int SR_CH_MASK        = 133
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic [15:0]          src_sid,
    input  logic [15:0]          dst_sid,
    mcf_source_multich_if.master o,
    output logic                 overrun
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = DATA_W - 4;

    typedef enum logic [1:0] {IDLE, SELECT, WAIT_TICK, SEND} state_t;
    state_t state, state_nxt;

    logic              enable, enable_d;
    logic [15:0]       spp, spp_eff, w_spp, pkt_cnt;
    logic [31:0]       sample_len, len_eff, w_len, burst_cnt;
    logic [31:0]       clk_div, w_div, div_cnt;
    logic [NUM_CH-1:0] ch_mask;
    logic              tick, valid, tlast, hs, pkt_last, burst_last, found;
    logic [CH_W-1:0]   cur_ch, last_ch, pick;
    int                rr_idx;
    logic [CNT_W-1:0]  samp_cnt [NUM_CH];
    logic [11:0]       seq [NUM_CH];
    logic              hdr_ht, hdr_eob;
    logic [11:0]       hdr_seq;
    logic [15:0]       hdr_src, hdr_dst;
    logic [63:0]       hdr_ts;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable     <= 1'b0;
            spp        <= 16'd1;
            sample_len <= 32'd1;
            clk_div    <= 32'd0;
            ch_mask    <= '1;
        end else if (set_stb) begin
            case (set_addr)
                8'(SR_ENABLE):         enable     <= set_data[0];
                8'(SR_SAMPLE_LEN_1MS): sample_len <= set_data;
                8'(SR_SPP):            spp        <= set_data[15:0];
                8'(SR_CLK_DIV):        clk_div    <= set_data;
                8'(SR_CH_MASK):        ch_mask    <= set_data[NUM_CH-1:0];
                default: ;
            endcase
        end
    end

    assign spp_eff = (spp == 16'd0) ? 16'd1 : spp;
    assign len_eff = (sample_len == 32'd0) ? 32'd1 : sample_len;
    assign tick    = (state != IDLE) && (div_cnt >= w_div);

    // Search starts just after the last served channel; last_ch resets to the top index.
    always_comb begin
        found  = 1'b0;
        pick   = last_ch;
        rr_idx = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            rr_idx = int'(last_ch) + i;
            if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
            if (!found && ch_mask[CH_W'(rr_idx)]) begin
                found = 1'b1;
                pick  = CH_W'(rr_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (enable && (|ch_mask)) state_nxt = SELECT;
            SELECT:    state_nxt = (enable && found) ? WAIT_TICK : IDLE;
            WAIT_TICK: if (tick) state_nxt = SEND;
            SEND: begin
                if (hs) begin
                    if (tlast && !enable) state_nxt = IDLE;
                    else if (burst_last)  state_nxt = SELECT;
                    else                  state_nxt = WAIT_TICK;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid      = (state == SEND);
        pkt_last   = (pkt_cnt == w_spp - 16'd1);
        burst_last = (burst_cnt == w_len - 32'd1);
        tlast      = valid && (pkt_last || burst_last);
        hs         = valid && o.tready;
        o.tvalid   = valid;
        o.tlast    = tlast;
        o.tdata    = valid ? {4'(cur_ch), samp_cnt[cur_ch]} : '0;
    end

    assign o.tuser = {2'b00, hdr_ht, hdr_eob, hdr_seq, 16'h0000, hdr_src, hdr_dst, hdr_ts};

`ifdef MCF_SRC_TIMESTAMP_EN
    localparam logic HAS_TIME = 1'b1;
    logic [63:0] ts_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= '0;
            hdr_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 64'd1;
            if (state == WAIT_TICK && tick && pkt_cnt == 16'd0) hdr_ts <= ts_cnt;
        end
    end
`else
    localparam logic HAS_TIME = 1'b0;
    assign hdr_ts = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_d  <= 1'b0;
            div_cnt   <= '0;
            w_spp     <= 16'd1;
            w_len     <= 32'd1;
            w_div     <= '0;
            cur_ch    <= '0;
            last_ch   <= CH_W'(NUM_CH - 1);
            pkt_cnt   <= '0;
            burst_cnt <= '0;
            hdr_ht    <= 1'b0;
            hdr_eob   <= 1'b0;
            hdr_seq   <= '0;
            hdr_src   <= '0;
            hdr_dst   <= '0;
            overrun   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                samp_cnt[c] <= '0;
                seq[c]      <= '0;
            end
        end else begin
            enable_d <= enable;
            div_cnt  <= (state == IDLE || tick) ? 32'd0 : div_cnt + 32'd1;

            if (state == SELECT && found && enable) begin
                cur_ch    <= pick;
                last_ch   <= pick;
                w_spp     <= spp_eff;
                w_len     <= len_eff;
                w_div     <= clk_div;
                pkt_cnt   <= '0;
                burst_cnt <= '0;
                hdr_ht    <= HAS_TIME;
                hdr_eob   <= (len_eff <= 32'(spp_eff));
                hdr_seq   <= seq[pick];
                hdr_src   <= src_sid;
                hdr_dst   <= dst_sid + 16'(pick);
            end

            if (hs) begin
                samp_cnt[cur_ch] <= samp_cnt[cur_ch] + 1'b1;
                burst_cnt        <= burst_cnt + 32'd1;
                pkt_cnt          <= tlast ? 16'd0 : pkt_cnt + 16'd1;
                if (tlast) seq[cur_ch] <= seq[cur_ch] + 12'd1;
            end

            // A disable mid-packet marks the packet in flight as end-of-burst.
            if (hs && tlast && !burst_last && enable) begin
                hdr_seq <= seq[cur_ch] + 12'd1;
                hdr_eob <= (w_len - burst_cnt - 32'd1 <= 32'(w_spp));
            end else if ((state == WAIT_TICK || state == SEND) && !enable) begin
                hdr_eob <= 1'b1;
            end

            if (enable && !enable_d)                       overrun <= 1'b0;
            else if (tick && state == SEND && !o.tready)   overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mcf_source_multich.sv
// Directed bench for mcf_source_multich: hand-computed sample/header streams per scenario.
module tb_mcf_source_multich;
    localparam logic [15:0] SRC = 16'hA5A5;
    localparam logic [15:0] DST = 16'h0100;
`ifdef MCF_SRC_TIMESTAMP_EN
    localparam bit HT = 1'b1;
`else
    localparam bit HT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic        overrun;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic [31:0]  q_dat [$];
    logic         q_last [$];
    logic [127:0] q_usr [$];
    int           q_cyc [$];

    int rr_ch  [8] = '{1, 1, 3, 3, 1, 1, 3, 3};
    int rr_cnt [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int rr_seq [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    mcf_source_multich_if #(.DATA_W(32)) axis ();

    mcf_source_multich dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .src_sid  (SRC),
        .dst_sid  (DST),
        .o        (axis),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && axis.tvalid && axis.tready) begin
            q_dat.push_back(axis.tdata);
            q_last.push_back(axis.tlast);
            q_usr.push_back(axis.tuser);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge clk); #2;
        set_stb = 1'b0;
    endtask

    task automatic do_reset();
        #1 reset_n = 1'b0;
        axis.tready = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        q_dat.delete(); q_last.delete(); q_usr.delete(); q_cyc.delete();
    endtask

    task automatic wait_n(input int n, input int budget);
        int k;
        k = 0;
        while (q_dat.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q_dat.size() < n) chk("timeout", q_dat.size(), n);
    endtask

    function automatic logic [63:0] hdr_hi(input logic eob, input int sq, input int ch);
        logic [11:0] s;
        logic [15:0] d;
        s = sq[11:0];
        d = DST + ch[15:0];
        return {2'b00, HT, eob, s, 16'h0000, SRC, d};
    endfunction

    initial begin
        logic [127:0] u, u0;
        int k;

        axis.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_tlast", axis.tlast, 0);
        chk("rst_tdata", axis.tdata, 0);
        chk("rst_tuser", axis.tuser, 0);
        chk("rst_overrun", overrun, 0);
        do_reset();

        // single channel, 4/4/2 packets
        wr(133, 1); wr(131, 4); wr(130, 10); wr(132, 0); wr(129, 1);
        wait_n(10, 300);
        for (int i = 0; i < 10; i++) begin
            u = q_usr[i];
            chk("t1_data", q_dat[i], i);
            chk("t1_last", q_last[i], (i % 4 == 3) || (i == 9));
            chk("t1_hdr", u[127:64], hdr_hi(i >= 8, i / 4, 0));
            if (i > 0) chk("t1_gap", q_cyc[i] - q_cyc[i-1], 2);
        end
        k = 0;
        while (!axis.tvalid && k < 50) begin @(negedge clk); k++; end
        chk("t1_inpkt", axis.tvalid, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_tvalid", axis.tvalid, 0);
        chk("arst_tdata", axis.tdata, 0);
        chk("arst_tuser", axis.tuser, 0);
        do_reset();

        // round-robin over ch1 and ch3
        wr(133, 32'hA); wr(131, 2); wr(130, 2); wr(129, 1);
        wait_n(8, 300);
        for (int i = 0; i < 8; i++) begin
            u = q_usr[i];
            chk("t2_data", q_dat[i], (rr_ch[i] << 28) | rr_cnt[i]);
            chk("t2_last", q_last[i], i % 2);
            chk("t2_hdr", u[127:64], hdr_hi(1'b1, rr_seq[i], rr_ch[i]));
        end
        do_reset();

        // pacing and stall
        wr(133, 1); wr(131, 4); wr(130, 1000); wr(132, 3); wr(129, 1);
        wait_n(2, 100);
        chk("t3_gap0", q_cyc[1] - q_cyc[0], 4);
        @(posedge clk); #2 axis.tready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t3_overrun", overrun, 1);
        chk("t3_stalled", q_dat.size(), 2);
        @(posedge clk); #2 axis.tready = 1'b1;
        wait_n(6, 100);
        for (int i = 0; i < 6; i++) chk("t3_data", q_dat[i], i);
        chk("t3_gap4", q_cyc[4] - q_cyc[3], 4);
        chk("t3_gap5", q_cyc[5] - q_cyc[4], 4);
        wr(129, 0); wr(129, 1);
        repeat (3) @(negedge clk);
        chk("t3_ovr_clr", overrun, 0);
        do_reset();

        // enable drop mid-packet
        wr(133, 1); wr(131, 4); wr(130, 100); wr(132, 0); wr(129, 1);
        wait_n(2, 100);
        wr(129, 0);
        repeat (20) @(negedge clk);
        chk("t4_count", q_dat.size(), 4);
        chk("t4_data2", q_dat[2], 2);
        chk("t4_data3", q_dat[3], 3);
        chk("t4_last2", q_last[2], 0);
        chk("t4_last3", q_last[3], 1);
        u = q_usr[3];
        chk("t4_eob", u[124], 1);
        chk("t4_idle", axis.tvalid, 0);
        do_reset();

        // SPP=0 / LEN=0 and sequence wrap
        wr(133, 1); wr(131, 0); wr(130, 0); wr(129, 1);
        wait_n(4097, 14000);
        for (int i = 0; i < 3; i++) begin
            u = q_usr[i];
            chk("t5_data", q_dat[i], i);
            chk("t5_last", q_last[i], 1);
            chk("t5_hdr", u[127:64], hdr_hi(1'b1, i, 0));
            if (i > 0) chk("t5_gap", q_cyc[i] - q_cyc[i-1], 3);
        end
        u = q_usr[4095];
        chk("t5_seq4095", u[123:112], 12'hFFF);
        u = q_usr[4096];
        chk("t5_seqwrap", u[123:112], 12'h000);
        chk("t5_data4096", q_dat[4096], 4096);
        do_reset();

        // mask zero while enabled
        wr(133, 0); wr(129, 1);
        repeat (20) @(negedge clk);
        chk("t6_nosamp", q_dat.size(), 0);
        chk("t6_tvalid", axis.tvalid, 0);
        do_reset();

        // timestamp field
        wr(133, 1); wr(131, 1); wr(130, 100); wr(129, 1);
        wait_n(4, 100);
        for (int i = 1; i < 4; i++) begin
            u  = q_usr[i];
            u0 = q_usr[i-1];
`ifdef MCF_SRC_TIMESTAMP_EN
            chk("t7_tsdiff", u[63:0] - u0[63:0], 2);
`else
            chk("t7_tszero", u[63:0], 0);
`endif
            chk("t7_hastime", u[125], HT);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
